ps2_line_assembler: RTL

- Sits directly upstream of the screen-character writer's terminal printer.
- Consumes raw PS/2 scan-code set 2 bytes from the keyboard controller and edits a working command line, with backspace support.
- On Enter, publishes the finished line as ps2_line_content with a one-cycle ps2_line_ready pulse.
- Also exposes the live edit buffer so the partially typed line can be echoed.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_scancode_to_ascii.sv | 53 +++++
 rtl/ps2_line_assembler.sv | 114 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code constants and decoder state type
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;
  localparam logic [7:0] PS2_BKSP   = 8'h66;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BREAK,
    EXT_BREAK
  } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// rtl/ps2_scancode_to_ascii.sv - combinational scan-code set 2 make code to ASCII decoder
module ps2_scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [4:0] letter_idx;
  logic       is_letter;

  // Letters resolve to an alphabet index so case selection happens in one place
  always_comb begin
    ascii      = 8'h00;
    valid      = 1'b0;
    letter_idx = 5'd0;
    is_letter  = 1'b1;
    case (code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: begin
        is_letter = 1'b0;
        valid     = 1'b1;
        case (code)
          8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;
          8'h1E: ascii = 8'h32;  8'h26: ascii = 8'h33;
          8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
          8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;
          8'h3E: ascii = 8'h38;  8'h46: ascii = 8'h39;
          8'h29: ascii = 8'h20;  8'h4E: ascii = 8'h2D;
          8'h49: ascii = 8'h2E;  8'h41: ascii = 8'h2C;
          default: valid = 1'b0;
        endcase
      end
    endcase
    if (is_letter) begin
      valid = 1'b1;
      ascii = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end
  end

endmodule

// File: rtl/ps2_line_assembler.sv
// rtl/ps2_line_assembler.sv - PS/2 line editor with commit on Enter; PS2_LOWERCASE_EN enables shift/caps lowercase
module ps2_line_assembler
  import ps2_pkg::*;
#(
  parameter int         MAX_CHARS = 32,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  localparam int        LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [7:0]               ps2_key_data,
  input  logic                     ps2_key_pressed,
  output logic [8*MAX_CHARS-1:0]   ps2_line_content,
  output logic                     ps2_line_ready,
  output logic [8*MAX_CHARS-1:0]   edit_content,
  output logic [LEN_W-1:0]         edit_length
);

  ps2_state_t       state;
  logic [7:0]       ascii;
  logic             ascii_valid;
  logic             upper;
  logic             make_hit;
  logic             ext_enter;
  logic [LEN_W-1:0] prev_len;
  logic [LEN_W+2:0] wr_base;
  logic [LEN_W+2:0] bs_base;

`ifdef PS2_LOWERCASE_EN
  logic shift_l;
  logic shift_r;
  logic caps_on;
  assign upper = caps_on ^ (shift_l | shift_r);
`else
  assign upper = 1'b1;
`endif

  // A byte in IDLE that is not a prefix is a make code; keypad Enter arrives via EXT
  assign make_hit  = ps2_key_pressed && (state == IDLE) &&
                     (ps2_key_data != PS2_EXT) && (ps2_key_data != PS2_BREAK);
  assign ext_enter = ps2_key_pressed && (state == EXT) && (ps2_key_data == PS2_ENTER);
  assign prev_len  = edit_length - LEN_W'(1);
  assign wr_base   = {edit_length, 3'b000};
  assign bs_base   = {prev_len, 3'b000};

  ps2_scancode_to_ascii u_decode (
    .code  (ps2_key_data),
    .upper (upper),
    .ascii (ascii),
    .valid (ascii_valid)
  );

  // Prefix decoder, edit buffer and commit path share one register stage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      ps2_line_content <= {MAX_CHARS{FILL_CHAR}};
      edit_content     <= {MAX_CHARS{FILL_CHAR}};
      edit_length      <= '0;
      ps2_line_ready   <= 1'b0;
`ifdef PS2_LOWERCASE_EN
      shift_l          <= 1'b0;
      shift_r          <= 1'b0;
      caps_on          <= 1'b0;
`endif
    end else begin
      ps2_line_ready <= 1'b0;
      if (ps2_key_pressed) begin
        case (state)
          IDLE: begin
            if (ps2_key_data == PS2_EXT)        state <= EXT;
            else if (ps2_key_data == PS2_BREAK) state <= BREAK;
          end
          EXT:     state <= (ps2_key_data == PS2_BREAK) ? EXT_BREAK : IDLE;
          BREAK: begin
`ifdef PS2_LOWERCASE_EN
            if (ps2_key_data == PS2_LSHIFT) shift_l <= 1'b0;
            if (ps2_key_data == PS2_RSHIFT) shift_r <= 1'b0;
`endif
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      if (make_hit || ext_enter) begin
        if (ps2_key_data == PS2_ENTER) begin
          if (edit_length != '0) begin
            ps2_line_content <= edit_content;
            ps2_line_ready   <= 1'b1;
            edit_content     <= {MAX_CHARS{FILL_CHAR}};
            edit_length      <= '0;
          end
        end else if (ps2_key_data == PS2_BKSP) begin
          if (edit_length != '0) begin
            edit_content[bs_base +: 8] <= FILL_CHAR;
            edit_length                <= prev_len;
          end
        end else if (ascii_valid) begin
          if (edit_length < LEN_W'(MAX_CHARS)) begin
            edit_content[wr_base +: 8] <= ascii;
            edit_length                <= edit_length + LEN_W'(1);
          end
        end
`ifdef PS2_LOWERCASE_EN
        if (ps2_key_data == PS2_LSHIFT) shift_l <= 1'b1;
        if (ps2_key_data == PS2_RSHIFT) shift_r <= 1'b1;
        if (ps2_key_data == PS2_CAPS)   caps_on <= ~caps_on;
`endif
      end
    end
  end

endmodule
